// File: rtl/mult_div_unit_pkg.sv
// Shared types for the iterative multiply/divide unit: op encodings, FSM states, latched control.
package mult_div_unit_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIX  = 2'b10
  } mdu_state_e;

  // Operation attributes captured when start is accepted
  typedef struct packed {
    logic is_div;
    logic neg_res;
    logic neg_rem;
    logic dbz;
  } md_ctrl_t;

  function automatic logic md_is_signed(input md_op_e op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

  function automatic logic md_is_div(input md_op_e op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/mdu_iter_core.sv
// One radix-2 step: shift-add multiply or restoring shift-subtract divide on a shared 2W accumulator.
module mdu_iter_core #(
  parameter int unsigned W = 32
) (
  input  logic [2*W-1:0] i_acc,
  input  logic [W-1:0]   i_opnd,
  input  logic           i_is_div,
  output logic [2*W-1:0] o_acc,
  output logic           o_q_bit
);

  logic [W:0]   w_mul_sum;
  logic [W:0]   w_div_shift;
  logic [W-1:0] w_div_sub;
  logic [W-1:0] w_div_rem;
  logic         w_div_ge;

  // Multiply: acc = {partial product, remaining multiplier bits}
  assign w_mul_sum = {1'b0, i_acc[2*W-1:W]} + (i_acc[0] ? {1'b0, i_opnd} : '0);

  // Divide: acc = {partial remainder, remaining dividend / quotient so far}
  assign w_div_shift = {i_acc[2*W-1:W], i_acc[W-1]};
  assign w_div_ge    = (w_div_shift >= {1'b0, i_opnd});
  assign w_div_sub   = W'(w_div_shift - {1'b0, i_opnd});
  assign w_div_rem   = w_div_ge ? w_div_sub : w_div_shift[W-1:0];

  always_comb begin
    o_acc   = {w_mul_sum, i_acc[W-1:1]};
    o_q_bit = 1'b0;
    if (i_is_div) begin
      o_acc   = {w_div_rem, i_acc[W-2:0], 1'b0};
      o_q_bit = w_div_ge;
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// EX-stage iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO and MTHI/MTLO writes.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            MDOp,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic                  MTHI,
  input  logic                  MTLO,
  output logic                  Busy,
  output logic                  Done,
  output logic [DATA_WIDTH-1:0] HI,
  output logic [DATA_WIDTH-1:0] LO
);

  localparam int unsigned W     = DATA_WIDTH;
  localparam int unsigned CNT_W = $clog2(DATA_WIDTH);

  mdu_state_e      r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2*W-1:0]  r_acc;
  logic [W-1:0]    r_opnd;
  md_ctrl_t        r_ctrl;
  logic [W-1:0]    r_hi;
  logic [W-1:0]    r_lo;
  logic            r_busy;
  logic            r_done;

  md_op_e          w_op;
  logic            w_signed;
  logic            w_is_div;
  logic            w_a_neg;
  logic            w_b_neg;
  logic [W-1:0]    w_a_mag;
  logic [W-1:0]    w_b_mag;
  md_ctrl_t        w_ctrl;
  logic [2*W-1:0]  w_acc_nxt;
  logic            w_q_bit;
  logic [2*W-1:0]  w_prod_fix;
  logic [W-1:0]    w_quo_fix;
  logic [W-1:0]    w_rem_fix;
  logic [W-1:0]    w_fix_hi;
  logic [W-1:0]    w_fix_lo;

  // Operand decode at start: magnitudes and result signs
  assign w_op     = md_op_e'(MDOp);
  assign w_signed = md_is_signed(w_op);
  assign w_is_div = md_is_div(w_op);
  assign w_a_neg  = w_signed & A[W-1];
  assign w_b_neg  = w_signed & B[W-1];
  assign w_a_mag  = w_a_neg ? -A : A;
  assign w_b_mag  = w_b_neg ? -B : B;

  always_comb begin
    w_ctrl         = '0;
    w_ctrl.is_div  = w_is_div;
    w_ctrl.neg_res = w_a_neg ^ w_b_neg;
    w_ctrl.neg_rem = w_a_neg;
    w_ctrl.dbz     = w_is_div && (B == '0);
  end

  mdu_iter_core #(
    .W(W)
  ) u_core (
    .i_acc    (r_acc),
    .i_opnd   (r_opnd),
    .i_is_div (r_ctrl.is_div),
    .o_acc    (w_acc_nxt),
    .o_q_bit  (w_q_bit)
  );

  // Sign fix-up of the unsigned magnitude result
  assign w_prod_fix = r_ctrl.neg_res ? -r_acc : r_acc;
  assign w_quo_fix  = r_ctrl.neg_res ? -r_acc[W-1:0] : r_acc[W-1:0];
  assign w_rem_fix  = r_ctrl.neg_rem ? -r_acc[2*W-1:W] : r_acc[2*W-1:W];

  always_comb begin
    w_fix_hi = w_prod_fix[2*W-1:W];
    w_fix_lo = w_prod_fix[W-1:0];
    if (r_ctrl.dbz) begin
      w_fix_hi = r_acc[2*W-1:W];
      w_fix_lo = r_acc[W-1:0];
    end else if (r_ctrl.is_div) begin
      w_fix_hi = w_rem_fix;
      w_fix_lo = w_quo_fix;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_opnd  <= '0;
      r_ctrl  <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // Moves are blocked in the Done cycle so the fresh result survives
          if (!r_done) begin
            if (MTHI) r_hi <= A;
            if (MTLO) r_lo <= A;
          end
          if (start) begin
            r_ctrl <= w_ctrl;
            r_cnt  <= CNT_W'(DATA_WIDTH - 1);
            r_busy <= 1'b1;
            if (w_ctrl.dbz) begin
              r_acc   <= {A, {W{1'b1}}};
              r_opnd  <= '0;
              r_state <= S_FIX;
            end else begin
              r_acc   <= {{W{1'b0}}, (w_is_div ? w_a_mag : w_b_mag)};
              r_opnd  <= w_is_div ? w_b_mag : w_a_mag;
              r_state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          // Quotient bit shifts into the LSB freed by the core
          r_acc <= w_acc_nxt | {{(2*W-1){1'b0}}, w_q_bit};
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == '0) r_state <= S_FIX;
        end
        S_FIX: begin
          r_hi    <= w_fix_hi;
          r_lo    <= w_fix_lo;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign Busy = r_busy;
  assign Done = r_done;
  assign HI   = r_hi;
  assign LO   = r_lo;

endmodule
